// File: rtl/seg_carry_assembler.sv
// Gathers compressor-tree segment sums least-significant first, ripples the
// carry between segments and presents the finished product with a valid/ready handshake.
module seg_carry_assembler #(
    parameter int SEG_W   = 18,
    parameter int SEG_NUM = 8,
    parameter int GROW_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      seg_valid,
    output logic                      seg_ready,
    input  logic [SEG_W+GROW_W-1:0]   seg_result,
    output logic                      prod_valid,
    input  logic                      prod_ready,
    output logic [SEG_W*SEG_NUM-1:0]  product,
    output logic                      prod_ovf
);

    localparam int RES_W = SEG_W + GROW_W;
    localparam int SUM_W = RES_W + 1;
    localparam int CAR_W = GROW_W + 1;
    localparam int IDX_W = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEG_NUM - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CAR_W-1:0]           carry_q, carry_d;
    logic [SEG_W*SEG_NUM-1:0]   product_q, product_d;
    logic                       valid_q, valid_d;
    logic                       ovf_q, ovf_d;

    logic [SUM_W-1:0]           sum;
    logic                       accept;

    // The sum is one bit wider than a segment result so the incoming carry never truncates.
    assign sum       = {1'b0, seg_result} + {{(SUM_W-CAR_W){1'b0}}, carry_q};
    assign seg_ready = (state_q == COLLECT) && !rst;
    assign accept    = seg_valid && seg_ready && !flush;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        product_d = product_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;

        if (flush) begin
            state_d = COLLECT;
            idx_d   = '0;
            carry_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == HOLD) begin
            if (prod_ready) begin
                state_d = COLLECT;
                idx_d   = '0;
                carry_d = '0;
                valid_d = 1'b0;
                ovf_d   = 1'b0;
            end
        end else if (accept) begin
            for (int s = 0; s < SEG_NUM; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    product_d[s*SEG_W +: SEG_W] = sum[SEG_W-1:0];
                end
            end
            carry_d = sum[SUM_W-1:SEG_W];
            if (idx_q == LAST_IDX) begin
                state_d = HOLD;
                valid_d = 1'b1;
                ovf_d   = |sum[SUM_W-1:SEG_W];
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            carry_q   <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            product_q <= product_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign product    = product_q;
    assign prod_valid = valid_q;
    assign prod_ovf   = ovf_q;

endmodule
